// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Contents: state codes, opcode constants, alu_op encodings (the ALU
// control unit uses the same alu_op values), the control-vector struct,
// and an opcode classification helper.
package mips_ctrl_pkg;

  // FSM state codes (4-bit register; codes 14 and 15 are unreachable)
  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_I_EXEC   = 4'd11;
  localparam logic [3:0] S_I_WB     = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // alu_op encodings
  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_FUNC = 3'b010;
  localparam logic [2:0] ALUOP_OR   = 3'b011;
  localparam logic [2:0] ALUOP_SLT  = 3'b100;
  localparam logic [2:0] ALUOP_AND  = 3'b101;

  // Complete set of datapath controls produced in one state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Immediate-ALU instructions that share the S_I_EXEC / S_I_WB path
  function automatic logic is_itype(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/control_salidas_decoder.sv
// Combinational Moore output decoder for the multicycle control FSM.
// Ports:
//   i_state      - current FSM state
//   i_op_latched - opcode captured in S_DECODE (selects alu_op/ext_zero
//                  in S_I_EXEC)
//   o_ctrl       - full datapath control vector; every field defaults to 0
module control_salidas_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic [5:0] i_op_latched,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.alu_src_b = 2'b01;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = 2'b00;
      end
      S_DECODE: begin
        // PC + (imm << 2) precomputed into ALUOut for a possible branch
        o_ctrl.alu_src_b = 2'b11;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b00;
        o_ctrl.alu_op    = ALUOP_FUNC;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = 2'b00;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = 2'b10;
      end
      S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = 2'b10;
        case (i_op_latched)
          OP_SLTI: o_ctrl.alu_op = ALUOP_SLT;
          OP_ANDI: begin
            o_ctrl.alu_op   = ALUOP_AND;
            o_ctrl.ext_zero = 1'b1;
          end
          OP_ORI: begin
            o_ctrl.alu_op   = ALUOP_OR;
            o_ctrl.ext_zero = 1'b1;
          end
          default: o_ctrl.alu_op = ALUOP_ADD;  // ADDI
        endcase
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_TRAP: begin
        o_ctrl.illegal_op = 1'b1;
      end
      default: o_ctrl = '0;  // S_RESET and unreachable codes
    endcase
  end

endmodule

// File: rtl/unidad_de_control_multiciclo.sv
// Multicycle MIPS main control unit: state register, opcode latch and
// next-state logic. Outputs are Moore, decoded from the state register
// (plus the latched opcode) by control_salidas_decoder.
// Ports:
//   clk, rst         - clock (rising edge), synchronous active-high reset
//   opcode           - IR[31:26], only looked at in S_DECODE
//   pc_write .. pc_source - datapath enables and mux selects
//   illegal_op       - high while parked in S_TRAP
//   state            - current state code for debug
module unidad_de_control_multiciclo
  import mips_ctrl_pkg::*;
#(
  parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [5:0] r_opcode;
  ctrl_t      w_ctrl;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_next_state;
  end

  // Opcode latch is pure data: later states use this copy so the live
  // IR field may change freely after S_DECODE.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) r_opcode <= opcode;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_RESET:  w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) w_next_state = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)                w_next_state = S_R_EXEC;
        else if (opcode == OP_BEQ)                  w_next_state = S_BRANCH;
        else if (opcode == OP_J)                    w_next_state = S_JUMP;
        else if (is_itype(opcode))                  w_next_state = S_I_EXEC;
        else if (TRAP_ON_ILLEGAL)                   w_next_state = S_TRAP;
        else                                        w_next_state = S_FETCH;
      end
      S_MEM_ADDR: w_next_state = (r_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = S_MEM_WB;
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = S_FETCH;
      S_R_EXEC:   w_next_state = S_R_WB;
      S_R_WB:     w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
      S_I_EXEC:   w_next_state = S_I_WB;
      S_I_WB:     w_next_state = S_FETCH;
      S_TRAP:     w_next_state = S_TRAP;
      default:    w_next_state = S_FETCH;  // codes 14/15 recover
    endcase
  end

  control_salidas_decoder u_salidas (
    .i_state      (r_state),
    .i_op_latched (r_opcode),
    .o_ctrl       (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign ext_zero      = w_ctrl.ext_zero;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign illegal_op    = w_ctrl.illegal_op;
  assign state         = r_state;

endmodule

// File: doc/unidad_de_control_multiciclo.md
Name: unidad_de_control_multiciclo

Overview:
Multicycle main control FSM for the MIPS datapath, directly upstream of the ALU control unit. It decodes the opcode held in the instruction register and sequences fetch/decode/execute/memory/writeback. It produces the 3-bit alu_op consumed by the ALU control unit, plus every datapath enable and mux select. Outputs are Moore-style, decoded only from the state register.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an illegal opcode parks the FSM in S_TRAP until reset; 0: an illegal opcode returns to S_FETCH (executes as a NOP).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]; sampled only in S_DECODE
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load when ALU zero=1 (BEQ)
i_or_d  out  1  memory address source: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
mem_to_reg  out  1  register write data: 0=ALUOut, 1=MDR
reg_dst  out  1  destination register: 0=rt, 1=rd
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A input: 0=PC, 1=register A
alu_src_b  out  2  ALU B input: 00=B, 01=constant 4, 10=extended imm, 11=extended imm<<2
ext_zero  out  1  immediate extension: 1=zero-extend (ANDI/ORI), 0=sign-extend
alu_op  out  3  000 add, 001 sub, 010 R-type(func), 011 or, 100 slt, 101 and
pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
illegal_op  out  1  high while in S_TRAP
state  out  4  current state, for debug/verification

Behaviour:
- Reset: clock and reset are decided as one clock (clk); reset is synchronous and active-high (rst). While rst=1 at a rising edge, the state register loads S_RESET(0). In S_RESET all outputs are 0 and state=0. The first edge with rst=0 moves to S_FETCH. Reset asserted in any state, mid-instruction, aborts the instruction on the next edge with no further write strobes.
- State encoding: S_RESET=0, S_FETCH=1, S_DECODE=2, S_MEM_ADDR=3, S_MEM_RD=4, S_MEM_WB=5, S_MEM_WR=6, S_R_EXEC=7, S_R_WB=8, S_BRANCH=9, S_JUMP=10, S_I_EXEC=11, S_I_WB=12, S_TRAP=13. Codes 14 and 15 are unreachable and recover to S_FETCH with all outputs 0.
- In every state, any output not listed for that state is 0.
- S_FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=000, pc_write=1, pc_source=00. Next state: S_DECODE.
- S_DECODE: alu_src_b=11, alu_op=000 (precomputes the branch target). Dispatch on opcode:
  - 100011 (LW) or 101011 (SW) -> S_MEM_ADDR
  - 000000 (R-type, includes SLL) -> S_R_EXEC
  - 000100 (BEQ) -> S_BRANCH
  - 000010 (J) -> S_JUMP
  - 001000 (ADDI), 001010 (SLTI), 001100 (ANDI), 001101 (ORI) -> S_I_EXEC
  - anything else -> S_TRAP if TRAP_ON_ILLEGAL, else S_FETCH
- Opcode latch: the opcode is captured into an internal register in S_DECODE. S_MEM_ADDR, S_I_EXEC and S_I_WB use only the latched copy, so opcode changes in other states have no effect.
- S_MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next: S_MEM_RD for LW, S_MEM_WR for SW.
- S_MEM_RD: mem_read=1, i_or_d=1. Next: S_MEM_WB.
- S_MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: S_FETCH.
- S_MEM_WR: mem_write=1, i_or_d=1. Next: S_FETCH.
- S_R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010. Next: S_R_WB.
- S_R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Next: S_FETCH.
- S_JUMP: pc_write=1, pc_source=10. Next: S_FETCH.
- S_I_EXEC: alu_src_a=1, alu_src_b=10. alu_op and ext_zero by latched opcode:
  - ADDI: alu_op=000, ext_zero=0
  - SLTI: alu_op=100, ext_zero=0
  - ANDI: alu_op=101, ext_zero=1
  - ORI: alu_op=011, ext_zero=1
  Next: S_I_WB.
- S_I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: S_FETCH.
- S_TRAP: illegal_op=1, all other outputs 0. Self-loop; exit only via rst.
- Instruction latency in cycles, counted from S_FETCH: LW 5; SW, R-type and I-type 4; BEQ and J 3.
- reg_write, mem_write and pc_write are never asserted in the same cycle, except pc_write in S_FETCH alone.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state localparams S_*
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI
  - alu_op encodings ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_FUNC=010, ALUOP_OR=011, ALUOP_SLT=100, ALUOP_AND=101
  The existing ALU control unit adopts the same alu_op constants.
- Sub-module: control_salidas_decoder, a purely combinational state(+latched opcode) -> output-vector decoder. The top level keeps the state register, opcode latch and next-state logic.

Test Plan:
- Reset: rst=1 for 2 cycles then release -> state=0 with all outputs 0 during reset; state=1 with mem_read=ir_write=pc_write=1 one cycle after release.
- LW (opcode 100011) -> state sequence 1,2,3,4,5,1; S_MEM_RD has mem_read=1, i_or_d=1; S_MEM_WB has reg_write=1, mem_to_reg=1.
- R-type (000000), then ORI (001101) -> R_EXEC has alu_op=010; R_WB has reg_dst=1. ORI's I_EXEC has alu_op=011, ext_zero=1; both instructions take 4 cycles.
- BEQ (000100), then J (000010) -> BRANCH has pc_write_cond=1, alu_op=001, pc_source=01; JUMP has pc_write=1, pc_source=10; each takes 3 cycles.
- Illegal opcode 111111 with TRAP_ON_ILLEGAL=1 -> state=13 and illegal_op=1 held for 10+ cycles; rst pulse returns state=0. With the parameter at 0 -> state returns to 1 directly after DECODE.
- Opcode switched from 001010 to 101011 during S_I_EXEC -> alu_op stays 100 and the FSM goes to S_I_WB (latched opcode used). rst asserted in S_MEM_WR -> next state 0, with no mem_write on the following cycle.
